// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the pipeline MEM stage.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses on err and suppress their effect.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LAT         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  load,
    input  logic [1:0]  store,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err
);
    localparam int         IW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateE;

    stateE          state;
    stateE          stateNxt;
    logic [31:0]    mem [DEPTH_WORDS];
    logic [3:0]     cnt;
    logic [31:0]    wordQ;
    logic [1:0]     laneQ;
    logic [2:0]     loadQ;
    logic           wrQ;
    logic           misQ;
    logic           accept;
    logic           misNow;
    logic [IW-1:0]  idx;
    logic [3:0]     laneMask;
    logic [31:0]    laneData;
    logic           unusedAddr;

    assign accept     = (state == IDLE) && req;
    assign idx        = addr[IW+1:2];
    assign unusedAddr = ^addr[31:IW+2];

`ifdef DMEM_ALIGN_CHECK_EN
    logic isByte;
    logic isHalf;

    assign isHalf = wr ? (store == 2'b10) : (load == 3'b011 || load == 3'b100);
    assign isByte = wr ? (store == 2'b01) : (load == 3'b001 || load == 3'b010);
    assign misNow = (isHalf && addr[0]) || (!isHalf && !isByte && addr[1:0] != 2'b00);
`else
    assign misNow = 1'b0;
`endif

    function automatic logic [31:0] extractLoad(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  ldType);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (ldType)
            3'b001:  return {{24{b[7]}}, b};
            3'b010:  return {24'h0, b};
            3'b011:  return {{16{h[15]}}, h};
            3'b100:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        laneMask = 4'b1111;
        laneData = wdata;
        case (store)
            2'b01: begin
                laneMask = 4'b0001 << addr[1:0];
                laneData = {4{wdata[7:0]}};
            end
            2'b10: begin
                laneMask = addr[1] ? 4'b1100 : 4'b0011;
                laneData = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // NOTE: the array has no reset; clearing every word is not a single-cycle operation,
    // and stores committed before a reset must survive it.
    always_ff @(posedge clk) begin
        if (rst && accept && wr && !misNow) begin
            for (int i = 0; i < 4; i++) begin
                if (laneMask[i]) mem[idx][8*i +: 8] <= laneData[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (req) stateNxt = (LAT == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) stateNxt = RESP;
            RESP:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_comb begin
        ack  = (state == RESP);
        busy = (state != IDLE);
`ifdef DMEM_ALIGN_CHECK_EN
        err  = (state == RESP) && misQ;
`else
        err  = 1'b0;
`endif
    end

    // The word is sampled at acceptance; the extended lane lands in rdata on the edge entering RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            wordQ <= '0;
            laneQ <= '0;
            loadQ <= '0;
            wrQ   <= 1'b0;
            misQ  <= 1'b0;
            rdata <= '0;
        end else if (accept) begin
            cnt   <= CNT_INIT;
            wordQ <= mem[idx];
            laneQ <= addr[1:0];
            loadQ <= load;
            wrQ   <= wr;
            misQ  <= misNow;
            if (LAT == 1 && !wr) rdata <= misNow ? '0 : extractLoad(mem[idx], addr[1:0], load);
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && !wrQ) rdata <= misQ ? '0 : extractLoad(wordQ, laneQ, loadQ);
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LAT=2, DEPTH_WORDS=1024).
module tb_dmem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  load;
    logic [1:0]  store;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    int passCnt  = 0;
    int checkCnt = 0;

    logic [31:0] rd;
    logic        alignEn;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LAT(LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .load  (load),
        .store (store),
        .ack   (ack),
        .rdata (rdata),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One complete access; returns rdata sampled during the ack cycle.
    task automatic access(input string nm, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] ld, input logic [1:0] st,
                          input logic expErr, output logic [31:0] rdOut);
        int edges;
        int busyCycles;
        wr = w; addr = a; wdata = d; load = ld; store = st; req = 1'b1;
        @(posedge clk); #1;
        edges      = 0;
        busyCycles = 0;
        while (!ack && edges < 20) begin
            if (busy) busyCycles++;
            @(posedge clk); #1;
            edges++;
        end
        if (busy) busyCycles++;
        req = 1'b0;
        check({nm, ":ack_latency"}, 32'(edges), 32'(LAT - 1));
        check({nm, ":busy_cycles"}, 32'(busyCycles), 32'(LAT));
        check({nm, ":err"}, {31'h0, err}, {31'h0, expErr});
        rdOut = rdata;
        @(posedge clk); #1;
        check({nm, ":idle_after"}, {30'h0, ack, busy}, 32'h0);
    endtask

    initial begin
`ifdef DMEM_ALIGN_CHECK_EN
        alignEn = 1'b1;
`else
        alignEn = 1'b0;
`endif
        rst = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; load = '0; store = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", {31'h0, ack}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Store accepted, then reset asserted while in WAIT
        wr = 1'b1; addr = 32'h50; wdata = 32'hA5A5A5A5; store = 2'b00; req = 1'b1;
        @(posedge clk); #1;
        check("mid_busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_ack", {31'h0, ack}, 32'h0);
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_ack", {31'h0, ack}, 32'h0);
        check("rst_hold_rdata", rdata, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        access("lw_after_rst", 1'b0, 32'h50, 32'h0, 3'b000, 2'b00, 1'b0, rd);
        check("store_survives_rst", rd, 32'hA5A5A5A5);

        // Word store / load; a store leaves rdata untouched
        access("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b000, 2'b00, 1'b0, rd);
        check("rdata_held_by_store", rd, 32'hA5A5A5A5);
        access("lw_10", 1'b0, 32'h10, 32'h0, 3'b000, 2'b00, 1'b0, rd);
        check("lw_10", rd, 32'hDEADBEEF);
        access("lw_other", 1'b0, 32'h10, 32'h0, 3'b111, 2'b00, 1'b0, rd);
        check("lw_other_type", rd, 32'hDEADBEEF);

        // Byte lanes and sign handling
        access("sw_20", 1'b1, 32'h20, 32'h0, 3'b000, 2'b11, 1'b0, rd);
        access("sb_22", 1'b1, 32'h22, 32'h000000F0, 3'b000, 2'b01, 1'b0, rd);
        access("lw_20", 1'b0, 32'h20, 32'h0, 3'b000, 2'b00, 1'b0, rd);
        check("lw_20", rd, 32'h00F00000);
        access("lb_22", 1'b0, 32'h22, 32'h0, 3'b001, 2'b00, 1'b0, rd);
        check("lb_22", rd, 32'hFFFFFFF0);
        access("lbu_22", 1'b0, 32'h22, 32'h0, 3'b010, 2'b00, 1'b0, rd);
        check("lbu_22", rd, 32'h000000F0);

        // Halfword lanes
        access("sw_30", 1'b1, 32'h30, 32'h0000BEEF, 3'b000, 2'b00, 1'b0, rd);
        access("sh_32", 1'b1, 32'h32, 32'h00008001, 3'b000, 2'b10, 1'b0, rd);
        access("lh_32", 1'b0, 32'h32, 32'h0, 3'b011, 2'b00, 1'b0, rd);
        check("lh_32", rd, 32'hFFFF8001);
        access("lhu_32", 1'b0, 32'h32, 32'h0, 3'b100, 2'b00, 1'b0, rd);
        check("lhu_32", rd, 32'h00008001);
        access("lw_30", 1'b0, 32'h30, 32'h0, 3'b000, 2'b00, 1'b0, rd);
        check("lw_30", rd, 32'h8001BEEF);

        // Address wrap-around modulo the array size
        access("sw_1000", 1'b1, 32'h1000, 32'h12345678, 3'b000, 2'b00, 1'b0, rd);
        access("lw_0", 1'b0, 32'h0, 32'h0, 3'b000, 2'b00, 1'b0, rd);
        check("wrap_lw_0", rd, 32'h12345678);

        // Misalignment: flagged and suppressed only with the alignment check built in
        access("sw_40", 1'b1, 32'h40, 32'h11223344, 3'b000, 2'b00, 1'b0, rd);
        access("sw_41", 1'b1, 32'h41, 32'hFFFFFFFF, 3'b000, 2'b00, alignEn, rd);
        access("lw_40", 1'b0, 32'h40, 32'h0, 3'b000, 2'b00, 1'b0, rd);
        check("lw_40", rd, alignEn ? 32'h11223344 : 32'hFFFFFFFF);
        access("lh_43", 1'b0, 32'h43, 32'h0, 3'b011, 2'b00, alignEn, rd);
        check("lh_43", rd, alignEn ? 32'h0 : 32'hFFFFFFFF);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
